// File: rtl/comparator_frame_reader_if.sv
// rtl/comparator_frame_reader_if.sv - read-side bus of the comparator FIFO
// master is the frame reader issuing rdreq; slave is the FIFO read port.
interface comparator_frame_reader_if #(
    parameter int DATA_W  = 8,
    parameter int USEDW_W = 11
);
    logic [DATA_W-1:0]  fifo_q;
    logic               fifo_rdempty;
    logic [USEDW_W-1:0] fifo_rdusedw;
    logic               fifo_rdreq;

    modport master (
        output fifo_rdreq,
        input  fifo_q,
        input  fifo_rdempty,
        input  fifo_rdusedw
    );

    modport slave (
        input  fifo_rdreq,
        output fifo_q,
        output fifo_rdempty,
        output fifo_rdusedw
    );
endinterface

// File: rtl/comparator_frame_reader.sv
// rtl/comparator_frame_reader.sv - drains FRAME_LEN-byte frames from a non-showahead FIFO
// and compares each frame against a masked reference, keeping saturating match counters.
module comparator_frame_reader #(
    parameter int FRAME_LEN = 4,
    parameter int DATA_W    = 8,
    parameter int USEDW_W   = 11,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        clr_counts,
    input  logic [DATA_W*FRAME_LEN-1:0] pattern,
    input  logic [DATA_W*FRAME_LEN-1:0] mask,
    comparator_frame_reader_if.master   fifo,
    output logic [DATA_W*FRAME_LEN-1:0] frame_data,
    output logic                        frame_valid,
    output logic                        match,
    output logic                        mismatch,
    output logic [CNT_W-1:0]            match_count,
    output logic [CNT_W-1:0]            mismatch_count,
    output logic                        busy
);
    localparam int FW = DATA_W * FRAME_LEN;
    localparam int IW = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT_LAST, S_RESULT} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     issued_q, issued_d;
    logic [IW-1:0]     cap_q, cap_d;
    logic              rdreq_q, rdreq_d;
    logic              rd_d1_q;
    logic [FW-1:0]     shift_q, shift_d;
    logic [FW-1:0]     frame_data_q, frame_data_d;
    logic              frame_valid_q, frame_valid_d;
    logic              match_q, match_d;
    logic              mismatch_q, mismatch_d;
    logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]  mismatch_cnt_q, mismatch_cnt_d;
    logic              busy_q;

    logic              qualify;
    logic [IW-1:0]     issued_inc;
    logic              last_cap;
    logic [FW-1:0]     shift_next;
    logic              cmp_ok;

    assign qualify    = enable && !fifo.fifo_rdempty &&
                        (fifo.fifo_rdusedw >= USEDW_W'(FRAME_LEN));
    assign issued_inc = issued_q + IW'(rdreq_q);
    assign last_cap   = rd_d1_q && (cap_q == IW'(FRAME_LEN - 1));
    assign shift_next = FW'({shift_q, fifo.fifo_q});
    assign cmp_ok     = (((shift_next ^ pattern) & mask) == '0);

    always_comb begin
        state_d        = state_q;
        issued_d       = issued_q;
        cap_d          = cap_q;
        rdreq_d        = 1'b0;
        shift_d        = shift_q;
        frame_data_d   = frame_data_q;
        frame_valid_d  = 1'b0;
        match_d        = 1'b0;
        mismatch_d     = 1'b0;
        match_cnt_d    = match_cnt_q;
        mismatch_cnt_d = mismatch_cnt_q;

        // Byte requested last cycle is on fifo_q now; rd_d1 qualifies the capture.
        if (rd_d1_q) begin
            shift_d = shift_next;
            cap_d   = last_cap ? '0 : cap_q + IW'(1);
        end

        case (state_q)
            S_IDLE, S_RESULT: begin
                // RESULT re-qualifies too, so back-to-back frames need no extra idle cycle.
                if (qualify) begin
                    state_d  = S_READ;
                    rdreq_d  = 1'b1;
                    issued_d = '0;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_READ: begin
                issued_d = issued_inc;
                if (issued_inc == IW'(FRAME_LEN)) begin
                    state_d = S_WAIT_LAST;
                end else begin
                    rdreq_d = !fifo.fifo_rdempty;
                end
            end
            S_WAIT_LAST: begin
                if (last_cap) begin
                    state_d       = S_RESULT;
                    frame_data_d  = shift_next;
                    frame_valid_d = 1'b1;
                    match_d       = cmp_ok;
                    mismatch_d    = !cmp_ok;
                    if (cmp_ok && (match_cnt_q != '1)) begin
                        match_cnt_d = match_cnt_q + CNT_W'(1);
                    end
                    if (!cmp_ok && (mismatch_cnt_q != '1)) begin
                        mismatch_cnt_d = mismatch_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (clr_counts) begin
            match_cnt_d    = '0;
            mismatch_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            issued_q       <= '0;
            cap_q          <= '0;
            rdreq_q        <= 1'b0;
            rd_d1_q        <= 1'b0;
            shift_q        <= '0;
            frame_data_q   <= '0;
            frame_valid_q  <= 1'b0;
            match_q        <= 1'b0;
            mismatch_q     <= 1'b0;
            match_cnt_q    <= '0;
            mismatch_cnt_q <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            issued_q       <= issued_d;
            cap_q          <= cap_d;
            rdreq_q        <= rdreq_d;
            rd_d1_q        <= rdreq_q;
            shift_q        <= shift_d;
            frame_data_q   <= frame_data_d;
            frame_valid_q  <= frame_valid_d;
            match_q        <= match_d;
            mismatch_q     <= mismatch_d;
            match_cnt_q    <= match_cnt_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            busy_q         <= (state_d != S_IDLE);
        end
    end

    assign fifo.fifo_rdreq = rdreq_q;
    assign frame_data      = frame_data_q;
    assign frame_valid     = frame_valid_q;
    assign match           = match_q;
    assign mismatch        = mismatch_q;
    assign match_count     = match_cnt_q;
    assign mismatch_count  = mismatch_cnt_q;
    assign busy            = busy_q;
endmodule

// File: tb/tb_comparator_frame_reader.sv
// tb/tb_comparator_frame_reader.sv - scoreboard bench with a queue-based FIFO and frame model
module tb_comparator_frame_reader;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int FW = DW * N;
    localparam int UW = 11;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          clr_counts = 1'b0;
    logic [FW-1:0] pattern = 32'hA55A0FF0;
    logic [FW-1:0] mask = 32'hFFFFFFFF;
    logic [FW-1:0] frame_data;
    logic          frame_valid, match, mismatch, busy;
    logic [CW-1:0] match_count, mismatch_count;

    comparator_frame_reader_if #(.DATA_W(DW), .USEDW_W(UW)) fif ();

    comparator_frame_reader #(.FRAME_LEN(N), .DATA_W(DW), .USEDW_W(UW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clr_counts(clr_counts),
        .pattern(pattern), .mask(mask), .fifo(fif),
        .frame_data(frame_data), .frame_valid(frame_valid), .match(match),
        .mismatch(mismatch), .match_count(match_count),
        .mismatch_count(mismatch_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] f;
        logic          m;
        logic [CW-1:0] mc;
        logic [CW-1:0] mmc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] fifo_mem[$];
    logic [7:0] wr_pend[$];
    logic [7:0] partial[$];
    int         checks = 0;
    int         errors = 0;
    int         mc_m = 0;
    int         mmc_m = 0;
    bit         clr_at_result = 0;
    bit         clr_drop = 0;
    int         cyc = 0;
    int         fv_times[$];
    int         run_len = 0;
    int         rdreq_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: a frame is the next N popped bytes, first byte most significant.
    task automatic model_frame();
        logic [FW-1:0] f = '0;
        exp_t e;
        for (int i = 0; i < N; i++) f = {f[FW-DW-1:0], partial[i]};
        e.f = f;
        e.m = (((f ^ pattern) & mask) == '0);
        if (clr_at_result) begin
            mc_m = 0; mmc_m = 0;
            clr_counts = 1'b1; clr_drop = 1; clr_at_result = 0;
        end else if (e.m) begin
            if (mc_m < 2**CW - 1) mc_m++;
        end else begin
            if (mmc_m < 2**CW - 1) mmc_m++;
        end
        e.mc  = CW'(mc_m);
        e.mmc = CW'(mmc_m);
        sb.push_back(e);
        partial.delete();
    endtask

    // Non-showahead FIFO: a request seen during a cycle pops at the edge ending it.
    initial begin
        logic       req;
        logic [7:0] b;
        fif.fifo_q = '0; fif.fifo_rdempty = 1'b1; fif.fifo_rdusedw = '0;
        forever begin
            @(negedge clk); req = fif.fifo_rdreq;
            @(posedge clk); #1;
            if (clr_drop) begin clr_counts = 1'b0; clr_drop = 0; end
            if (req) begin
                if (fifo_mem.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL fifo_underflow actual=read_from_empty expected=no_read");
                end else begin
                    b = fifo_mem.pop_front();
                    fif.fifo_q = b;
                    partial.push_back(b);
                    if (partial.size() == N) model_frame();
                end
            end
            while (wr_pend.size() > 0) fifo_mem.push_back(wr_pend.pop_front());
            fif.fifo_rdusedw = UW'(fifo_mem.size());
            fif.fifo_rdempty = (fifo_mem.size() == 0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            run_len = 0;
        end else begin
            if (fif.fifo_rdreq) begin
                run_len++; rdreq_seen++;
            end else if (run_len > 0) begin
                chk("rdreq_burst_len", run_len, N);
                run_len = 0;
            end
            if (frame_valid) begin
                fv_times.push_back(cyc);
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_frame actual=%0h expected=no_frame", frame_data);
                end else begin
                    e = sb.pop_front();
                    chk("frame_data", frame_data, e.f);
                    chk("match", match, e.m);
                    chk("mismatch", mismatch, !e.m);
                    chk("match_count", match_count, e.mc);
                    chk("mismatch_count", mismatch_count, e.mmc);
                end
            end else if (match || mismatch) begin
                checks++; errors++;
                $display("FAIL stray_pulse actual=%0b%0b expected=00", match, mismatch);
            end
        end
    end

    task automatic wb(input logic [7:0] b);
        wr_pend.push_back(b);
    endtask

    task automatic write_rand(input int n);
        for (int i = 0; i < n; i++) wr_pend.push_back(8'($urandom));
    endtask

    task automatic write_frame(input logic [FW-1:0] f);
        for (int i = 0; i < N; i++) wr_pend.push_back(f[FW-1-8*i -: 8]);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int  n = 0;
        bit  pending = 1;
        while (pending && n < budget) begin
            @(negedge clk); #1; n++;
            pending = (sb.size() > 0 || fifo_mem.size() > 0 || wr_pend.size() > 0 ||
                       partial.size() > 0 || busy);
        end
        if (pending) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual=busy expected=idle_within_%0d", name, budget);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #5ms;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        logic [FW-1:0] f, msk;

        repeat (3) @(negedge clk);
        chk("reset_frame_data", frame_data, 0);
        chk("reset_frame_valid", frame_valid, 0);
        chk("reset_match_count", match_count, 0);
        chk("reset_mismatch_count", mismatch_count, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rdreq", fif.fifo_rdreq, 0);
        rst = 1'b0; enable = 1'b1;

        wb(8'hA5); wb(8'h5A); wb(8'h0F); wb(8'hF0);
        wait_idle("t1", 100);
        chk("t1_match_count", match_count, 1);
        chk("t1_mismatch_count", mismatch_count, 0);

        wb(8'hA5); wb(8'h5A); wb(8'h0F); wb(8'hF1);
        wait_idle("t2a", 100);
        chk("t2a_mismatch_count", mismatch_count, 1);
        mask = 32'hFFFFFFFE;
        wb(8'hA5); wb(8'h5A); wb(8'h0F); wb(8'hF1);
        wait_idle("t2b", 100);
        chk("t2b_match_count", match_count, 2);
        mask = 32'hFFFFFFFF;

        rdreq_seen = 0;
        write_rand(3);
        repeat (20) @(negedge clk);
        chk("t3_no_rdreq", rdreq_seen, 0);
        chk("t3_idle", busy, 0);
        write_rand(1);
        @(posedge clk); #3;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!fif.fifo_rdreq && lat < 10);
        chk("t3_start_latency", lat, 2);
        wait_idle("t3", 100);

        for (int k = 0; k < 8; k++) begin
            f = $urandom; msk = $urandom;
            mask = msk;
            pattern = $urandom_range(0, 1) ? (f ^ ($urandom & ~msk)) : (f ^ $urandom);
            write_frame(f);
            wait_idle("rand", 100);
        end

        pattern = 32'hA55A0FF0; mask = 32'hFFFFFFFF;
        fv_times.delete();
        write_rand(12);
        wait_idle("t4", 200);
        chk("t4_frames", fv_times.size(), 3);
        if (fv_times.size() == 3) begin
            chk("t4_spacing_1", fv_times[1] - fv_times[0], N + 2);
            chk("t4_spacing_2", fv_times[2] - fv_times[1], N + 2);
        end
        chk("t4_fifo_empty", fif.fifo_rdempty, 1);

        write_rand(6);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!fif.fifo_rdreq && lat < 10);
        @(posedge clk); #2; rst = 1'b1;
        @(posedge clk); #2;
        partial.delete(); mc_m = 0; mmc_m = 0; rst = 1'b0;
        chk("t5_rdreq_after_rst", fif.fifo_rdreq, 0);
        chk("t5_busy_after_rst", busy, 0);
        chk("t5_valid_after_rst", frame_valid, 0);
        chk("t5_counts_after_rst", {match_count, mismatch_count}, 0);
        wait_idle("t5", 100);
        chk("t5_total_frames", match_count + mismatch_count, 1);

        write_rand(8);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!fif.fifo_rdreq && lat < 10);
        @(negedge clk); enable = 1'b0;
        repeat (30) @(negedge clk);
        chk("t6_frames_pending", sb.size(), 0);
        chk("t6_left_in_fifo", fifo_mem.size(), 4);
        chk("t6_idle", busy, 0);
        enable = 1'b1;
        wait_idle("t6", 100);

        fv_times.delete();
        write_rand(1024);
        wait_idle("t7", 3000);
        chk("t7_full_fifo_frames", fv_times.size(), 256);

        mask = '0;
        write_rand(17 * N);
        wait_idle("t8", 400);
        chk("t8_match_saturated", match_count, 2**CW - 1);

        clr_at_result = 1;
        write_rand(N);
        wait_idle("t9", 100);
        chk("t9_clr_wins_match", match_count, 0);
        chk("t9_clr_wins_mismatch", mismatch_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
